// File: rtl/shot_sequencer.sv
// rtl/shot_sequencer.sv - battleship turn controller: fire sync, shot resolve, score and win/lose
module shot_sequencer #(
  parameter int NCELLS   = 16,
  parameter int ADDRW    = 4,
  parameter int MAXSHOTS = 10,
  parameter int SHOWCYC  = 4,
  parameter int SW       = $clog2(MAXSHOTS + 1),
  parameter int HW       = $clog2(NCELLS + 1)
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              START,
  input  logic              BTNIPT,
  input  logic [ADDRW-1:0]  SEL,
  input  logic [NCELLS-1:0] SHIPMAP,
  output logic              OUT,
  output logic              GLED,
  output logic              RLED,
  output logic              RPTLED,
  output logic [SW-1:0]     SHOTS,
  output logic [HW-1:0]     HITSLEFT,
  output logic [2:0]        STATE,
  output logic              WIN,
  output logic              LOSE
);

  localparam int CW = (SHOWCYC > 1) ? $clog2(SHOWCYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AIM     = 3'd1,
    S_RESOLVE = 3'd2,
    S_SHOW    = 3'd3,
    S_WIN     = 3'd4,
    S_LOSE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_HIT  = 2'd1,
    RES_MISS = 2'd2,
    RES_RPT  = 2'd3
  } result_t;

  state_t              state_q, state_n;
  result_t             result_q, result_n;
  logic [NCELLS-1:0]   ship_q, ship_n;
  logic [NCELLS-1:0]   fired_q, fired_n;
  logic [ADDRW-1:0]    tgt_q, tgt_n;
  logic [CW-1:0]       hold_q, hold_n;
  logic [SW-1:0]       shots_q, shots_n;
  logic [HW-1:0]       hits_q, hits_n;
  logic                out_n, gled_n, rled_n, rpt_n, win_n, lose_n;
  logic                s1, s2, s3;
  logic                fire;
  logic                tgt_ok;
  logic [HW-1:0]       pop;

  // Button comes from another clock domain: two flops to settle, a third to find the rising edge
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= BTNIPT;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fire   = s2 & ~s3;
  assign tgt_ok = ({1'b0, tgt_q} < (ADDRW + 1)'(NCELLS));

  // Number of ship cells on the incoming map, used as the starting hits-left count
  always_comb begin
    pop = '0;
    for (int i = 0; i < NCELLS; i++) begin
      pop = pop + HW'(SHIPMAP[i]);
    end
  end

  // Game state register and all registered outputs
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q  <= S_IDLE;
      result_q <= RES_NONE;
      ship_q   <= '0;
      fired_q  <= '0;
      tgt_q    <= '0;
      hold_q   <= '0;
      shots_q  <= '0;
      hits_q   <= '0;
      OUT      <= 1'b0;
      GLED     <= 1'b0;
      RLED     <= 1'b0;
      RPTLED   <= 1'b0;
      WIN      <= 1'b0;
      LOSE     <= 1'b0;
    end else begin
      state_q  <= state_n;
      result_q <= result_n;
      ship_q   <= ship_n;
      fired_q  <= fired_n;
      tgt_q    <= tgt_n;
      hold_q   <= hold_n;
      shots_q  <= shots_n;
      hits_q   <= hits_n;
      OUT      <= out_n;
      GLED     <= gled_n;
      RLED     <= rled_n;
      RPTLED   <= rpt_n;
      WIN      <= win_n;
      LOSE     <= lose_n;
    end
  end

  // Next-state, scoring and next-output logic; outputs are derived from the state being entered
  always_comb begin
    state_n  = state_q;
    result_n = result_q;
    ship_n   = ship_q;
    fired_n  = fired_q;
    tgt_n    = tgt_q;
    hold_n   = hold_q;
    shots_n  = shots_q;
    hits_n   = hits_q;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        // START takes precedence; any fire pulse in these states is discarded
        if (START) begin
          ship_n   = SHIPMAP;
          fired_n  = '0;
          shots_n  = SW'(MAXSHOTS);
          hits_n   = pop;
          result_n = RES_NONE;
          state_n  = (pop == '0) ? S_WIN : S_AIM;
        end
      end
      S_AIM: begin
        if (fire) begin
          tgt_n   = SEL;
          state_n = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (!tgt_ok || fired_q[tgt_q]) begin
          result_n = RES_RPT;
        end else begin
          fired_n[tgt_q] = 1'b1;
          if (shots_q != '0) shots_n = shots_q - SW'(1);
          if (ship_q[tgt_q]) begin
            if (hits_q != '0) hits_n = hits_q - HW'(1);
            result_n = RES_HIT;
          end else begin
            result_n = RES_MISS;
          end
        end
        hold_n  = CW'(SHOWCYC - 1);
        state_n = S_SHOW;
      end
      S_SHOW: begin
        // Sinking the last ship wins even if that was the last shot
        if (hold_q == '0) begin
          if (hits_q == '0)       state_n = S_WIN;
          else if (shots_q == '0) state_n = S_LOSE;
          else                    state_n = S_AIM;
        end else begin
          hold_n = hold_q - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    out_n  = (state_q == S_RESOLVE) && (result_n == RES_HIT);
    gled_n = (state_n == S_SHOW) && (result_n == RES_HIT);
    rled_n = (state_n == S_SHOW) && (result_n == RES_MISS);
    rpt_n  = (state_n == S_SHOW) && (result_n == RES_RPT);
    win_n  = (state_n == S_WIN);
    lose_n = (state_n == S_LOSE);
  end

  assign SHOTS    = shots_q;
  assign HITSLEFT = hits_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// tb/tb_shot_sequencer.sv - self-checking bench for shot_sequencer
module tb_shot_sequencer;

  localparam int MAXS  = 3;
  localparam int SHOWC = 4;
  localparam int SWB   = $clog2(MAXS + 1);
  localparam int HWB   = $clog2(16 + 1);

  localparam int L_HIT = 0, L_MISS = 1, L_RPT = 2;
  localparam int ST_IDLE = 0, ST_AIM = 1, ST_RES = 2, ST_SHOW = 3, ST_WIN = 4, ST_LOSE = 5;

  logic            CLK, NRST, START, BTNIPT;
  logic [3:0]      SEL;
  logic [15:0]     SHIPMAP;
  logic            OUT, GLED, RLED, RPTLED, WIN, LOSE;
  logic [SWB-1:0]  SHOTS;
  logic [HWB-1:0]  HITSLEFT;
  logic [2:0]      STATE;

  int nchecks = 0;
  int nerr    = 0;

  shot_sequencer #(
    .NCELLS(16), .ADDRW(4), .MAXSHOTS(MAXS), .SHOWCYC(SHOWC)
  ) dut (
    .CLK(CLK), .NRST(NRST), .START(START), .BTNIPT(BTNIPT), .SEL(SEL),
    .SHIPMAP(SHIPMAP), .OUT(OUT), .GLED(GLED), .RLED(RLED), .RPTLED(RPTLED),
    .SHOTS(SHOTS), .HITSLEFT(HITSLEFT), .STATE(STATE), .WIN(WIN), .LOSE(LOSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        newgame;
    logic [15:0] map;
    logic [3:0]  sel;
    int          hold;
    int          led;
    int          shots;
    int          hits;
    int          st;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_game(input logic [15:0] map);
    int pc;
    pc = $countones(map);
    SHIPMAP = map;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("load shots", SHOTS, MAXS);
    chk("load hitsleft", HITSLEFT, pc);
    chk("load state", STATE, (pc == 0) ? ST_WIN : ST_AIM);
    chk("load win", WIN, (pc == 0) ? 1 : 0);
  endtask

  // One press of the fire button; observes the whole LED window plus a quiet tail
  task automatic do_shot(input logic [3:0] sel, input int hold,
                         output int led, output int ledcyc, output int outcnt,
                         output int events, output int multi);
    int  c;
    logic any, prev_any;
    led = -1; ledcyc = 0; outcnt = 0; events = 0; multi = 0;
    prev_any = 1'b0;
    SEL = sel;
    c = 0;
    while (c < 80) begin
      BTNIPT = (c < hold);
      step();
      any = GLED | RLED | RPTLED;
      if ($countones({GLED, RLED, RPTLED}) > 1) multi++;
      if (any && !prev_any) events++;
      if (any) begin
        ledcyc++;
        led = GLED ? L_HIT : (RLED ? L_MISS : L_RPT);
      end
      if (OUT) outcnt++;
      prev_any = any;
      c++;
      if (events > 0 && !any && c >= hold) break;
    end
    BTNIPT = 1'b0;
    repeat (4) begin
      step();
      any = GLED | RLED | RPTLED;
      if (any && !prev_any) events++;
      if (any) ledcyc++;
      if (OUT) outcnt++;
      prev_any = any;
    end
  endtask

  task automatic shot_checks(input string tag, input int led, input int ledcyc,
                             input int outcnt, input int events, input int multi,
                             input int eled, input int eshots, input int ehits, input int est);
    chk({tag, " led"}, led, eled);
    chk({tag, " ledcyc"}, ledcyc, SHOWC);
    chk({tag, " events"}, events, 1);
    chk({tag, " outcnt"}, outcnt, (eled == L_HIT) ? 1 : 0);
    chk({tag, " multi"}, multi, 0);
    chk({tag, " shots"}, SHOTS, eshots);
    chk({tag, " hits"}, HITSLEFT, ehits);
    chk({tag, " state"}, STATE, est);
    chk({tag, " win"}, WIN, (est == ST_WIN) ? 1 : 0);
    chk({tag, " lose"}, LOSE, (est == ST_LOSE) ? 1 : 0);
  endtask

  // Random game scored by a shot-level model of the rules
  task automatic random_game();
    logic [15:0] map, mf;
    int ms, mh, t, eled, est;
    int led, ledcyc, outcnt, events, multi;
    map = 16'($urandom) & 16'($urandom) & 16'h00FF;
    start_game(map);
    ms = MAXS; mh = $countones(map); mf = '0;
    if (mh == 0) return;
    for (int k = 0; k < 20; k++) begin
      t = $urandom_range(0, 7);
      if (k >= 8) begin
        for (int j = 0; j < 16; j++) begin
          if (!mf[j]) begin
            t = j;
            break;
          end
        end
      end
      if (mf[t]) begin
        eled = L_RPT;
      end else begin
        mf[t] = 1'b1;
        ms--;
        if (map[t]) begin
          mh--;
          eled = L_HIT;
        end else begin
          eled = L_MISS;
        end
      end
      est = (mh == 0) ? ST_WIN : ((ms == 0) ? ST_LOSE : ST_AIM);
      do_shot(4'(t), $urandom_range(1, 6), led, ledcyc, outcnt, events, multi);
      shot_checks("rnd", led, ledcyc, outcnt, events, multi, eled, ms, mh, est);
      if (est != ST_AIM) break;
    end
  endtask

  initial begin
    int led, ledcyc, outcnt, events, multi, n, cyc, resolves, bad;

    tbl[0]  = '{1'b1, 16'h0001, 4'd0, 2,  L_HIT,  2, 0, ST_WIN};
    tbl[1]  = '{1'b1, 16'h0003, 4'd5, 1,  L_MISS, 2, 2, ST_AIM};
    tbl[2]  = '{1'b0, 16'h0003, 4'd5, 20, L_RPT,  2, 2, ST_AIM};
    tbl[3]  = '{1'b0, 16'h0003, 4'd0, 3,  L_HIT,  1, 1, ST_AIM};
    tbl[4]  = '{1'b0, 16'h0003, 4'd1, 2,  L_HIT,  0, 0, ST_WIN};
    tbl[5]  = '{1'b1, 16'h0003, 4'd4, 1,  L_MISS, 2, 2, ST_AIM};
    tbl[6]  = '{1'b0, 16'h0003, 4'd5, 4,  L_MISS, 1, 2, ST_AIM};
    tbl[7]  = '{1'b0, 16'h0003, 4'd6, 2,  L_MISS, 0, 2, ST_LOSE};
    tbl[8]  = '{1'b1, 16'h0003, 4'd1, 7,  L_HIT,  2, 1, ST_AIM};
    tbl[9]  = '{1'b0, 16'h0003, 4'd9, 1,  L_MISS, 1, 1, ST_AIM};
    tbl[10] = '{1'b0, 16'h0003, 4'd0, 2,  L_HIT,  0, 0, ST_WIN};

    NRST = 1'b0; START = 1'b0; BTNIPT = 1'b1; SEL = '0; SHIPMAP = '0;

    // Reset with the button held, then keep holding after release
    repeat (3) step();
    chk("rst state", STATE, ST_IDLE);
    chk("rst shots", SHOTS, 0);
    chk("rst out", OUT, 0);
    chk("rst outputs", {GLED, RLED, RPTLED, WIN, LOSE, HITSLEFT}, 0);
    NRST = 1'b1;
    bad = 0;
    repeat (6) begin
      step();
      if (STATE != ST_IDLE) bad++;
    end
    chk("held btn idle", bad, 0);
    BTNIPT = 1'b0;
    repeat (3) step();

    // Fire timing: RESOLVE two edges after first sampling, then hit window
    start_game(16'h0001);
    SEL = 4'd0;
    BTNIPT = 1'b1;
    step(); chk("edge n state", STATE, ST_AIM);
    step(); chk("edge n+1 state", STATE, ST_AIM);
    step(); chk("edge n+2 resolve", STATE, ST_RES);
    BTNIPT = 1'b0;
    chk("resolve out", OUT, 0);
    step();
    chk("show state", STATE, ST_SHOW);
    chk("show out first", OUT, 1);
    chk("show gled 1", GLED, 1);
    chk("hit shots", SHOTS, 2);
    chk("hit hitsleft", HITSLEFT, 0);
    step(); chk("show out second", OUT, 0); chk("show gled 2", GLED, 1);
    step(); step(); chk("show gled 4", GLED, 1);
    step(); chk("gled off", GLED, 0); chk("win", WIN, 1); chk("win state", STATE, ST_WIN);

    // START together with a fire pulse: load happens, fire is dropped
    SHIPMAP = 16'h0003; SEL = 4'd2;
    BTNIPT = 1'b1;
    step(); step();
    START = 1'b1;
    step();
    START = 1'b0; BTNIPT = 1'b0;
    chk("start+fire state", STATE, ST_AIM);
    chk("start+fire shots", SHOTS, MAXS);
    step(); step();
    chk("fire dropped", STATE, ST_AIM);

    // Second press during SHOW is dropped
    SEL = 4'd7; BTNIPT = 1'b1; step(); BTNIPT = 1'b0;
    n = 0;
    while (!RLED && n < 10) begin step(); n++; end
    chk("rled seen", RLED, 1);
    cyc = 1; resolves = 0;
    BTNIPT = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 1) BTNIPT = 1'b0;
      if (RLED) cyc++;
      if (STATE == ST_RES) resolves++;
    end
    chk("rled cycles", cyc, SHOWC);
    chk("show press resolves", resolves, 0);
    chk("show press shots", SHOTS, 2);
    chk("show press state", STATE, ST_AIM);

    // START during AIM is ignored
    START = 1'b1; step(); step(); START = 1'b0;
    chk("aim start state", STATE, ST_AIM);
    chk("aim start shots", SHOTS, 2);

    // Reset in the middle of SHOW
    SEL = 4'd8; BTNIPT = 1'b1; step(); BTNIPT = 1'b0;
    n = 0;
    while (!RLED && n < 10) begin step(); n++; end
    chk("pre-reset rled", RLED, 1);
    NRST = 1'b0; step();
    chk("midshow rst state", STATE, ST_IDLE);
    chk("midshow rst outputs", {OUT, GLED, RLED, RPTLED, WIN, LOSE, SHOTS, HITSLEFT}, 0);
    NRST = 1'b1; step();

    // Table-driven games
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].newgame) start_game(tbl[i].map);
      do_shot(tbl[i].sel, tbl[i].hold, led, ledcyc, outcnt, events, multi);
      shot_checks($sformatf("vec%0d", i), led, ledcyc, outcnt, events, multi,
                  tbl[i].led, tbl[i].shots, tbl[i].hits, tbl[i].st);
    end

    // Empty ship map goes straight to WIN
    start_game(16'h0000);
    step();
    chk("empty win hold", STATE, ST_WIN);

    // Randomized games against the shot-level model
    for (int g = 0; g < 20; g++) random_game();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Turn controller for the battleship board. It wraps the per-cell hit/miss evaluation in a clocked game loop.
- Sequencing per shot: synchronises and edge-detects the fire button, latches the target cell, and rejects repeat shots.
- Keeps score: counts down remaining shots and unsunk ship cells, holds the hit/miss LEDs for a display window, and declares WIN or LOSE.
- Sits between the board switches/buttons and the LED/7-seg display logic.

Parameters:
- NCELLS, 16, number of board cells.
- ADDRW, 4, width of cell index; NCELLS <= 2**ADDRW.
- MAXSHOTS, 10, shots allowed per game.
- SHOWCYC, 4, cycles the result LEDs are held (>=1).
- SW, $clog2(MAXSHOTS+1), shot counter width.
- HW, $clog2(NCELLS+1), hits-left counter width.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- NRST  in  1  synchronous, active-low reset.
- START  in  1  level; begins or restarts a game from IDLE/WIN/LOSE.
- BTNIPT  in  1  raw fire button, active-high, asynchronous to CLK.
- SEL  in  ADDRW  target cell index.
- SHIPMAP  in  NCELLS  ship bitmap, 1 = ship; sampled only at game start.
- OUT  out  1  one-cycle pulse on a valid hit.
- GLED  out  1  hit indicator, high for the whole SHOW window.
- RLED  out  1  miss indicator, high for the whole SHOW window.
- RPTLED  out  1  repeat/invalid-shot indicator, high for the whole SHOW window.
- SHOTS  out  SW  remaining shots.
- HITSLEFT  out  HW  unsunk ship cells.
- STATE  out  3  FSM state code.
- WIN  out  1  high while in WIN.
- LOSE  out  1  high while in LOSE.

Behaviour:
- Reset (NRST=0 at a rising edge):
  - STATE=IDLE; all outputs 0; SHOTS=0; HITSLEFT=0.
  - Ship map, fired map and the sync chain are cleared.
  - Reset overrides everything, mid-game included.
- Button sync:
  - 3-flop chain s1<-BTNIPT, s2<-s1, s3<-s2; fire = s2 & ~s3.
  - BTNIPT first sampled high at edge n: the FSM acts on fire at edge n+2.
  - One fire pulse per press regardless of hold length.
- State codes: IDLE=0, AIM=1, RESOLVE=2, SHOW=3, WIN=4, LOSE=5.
- Game load, taken from IDLE, WIN or LOSE when START=1:
  - ship map <= SHIPMAP; fired map <= 0; SHOTS <= MAXSHOTS; HITSLEFT <= popcount(SHIPMAP).
  - Next state is AIM, or WIN if popcount=0.
  - START with a simultaneous fire: START wins and the fire is dropped.
- AIM: on fire, latch SEL into tgt and go to RESOLVE. START is ignored.
- RESOLVE (exactly one cycle):
  - Repeat/invalid shot (tgt >= NCELLS, or fired[tgt]=1): set result=RPT; SHOTS and HITSLEFT unchanged.
  - Otherwise: fired[tgt] <= 1 and SHOTS--.
  - Hit (ship[tgt]=1): additionally HITSLEFT-- and result=HIT. Miss: result=MISS.
  - Load hold counter to SHOWCYC-1, then go to SHOW.
- SHOW:
  - Exactly one of GLED/RLED/RPTLED is high for SHOWCYC cycles, per result.
  - OUT is high only in the first SHOW cycle, and only when result=HIT.
  - Counter decrements each cycle. At 0, priority: HITSLEFT==0 -> WIN; else SHOTS==0 -> LOSE; else AIM.
  - Fire pulses during SHOW are dropped (not queued).
- Last shot sinks last ship: WIN has priority over LOSE.
- WIN/LOSE: hold; LEDs off; fire ignored; START reloads per game load.
- All outputs are registered; counters never wrap (decrement is guarded by the rules above).

Test Plan:
- Reset with BTNIPT held high -> STATE=0, SHOTS=0, OUT=0. Release NRST and keep holding: no state change; stays IDLE.
- Hit: MAXSHOTS=3, SHOWCYC=4, SHIPMAP=16'h0001, START, SEL=0, press -> RESOLVE at edge n+2. Then OUT 1 cycle, GLED 4 cycles, SHOTS=2, HITSLEFT=0, then WIN=1.
- Miss then repeat: SHIPMAP=16'h0003, fire at 5 -> RLED 4 cycles, SHOTS=2. Fire at 5 again -> RPTLED 4 cycles, SHOTS=2, HITSLEFT=2, return to AIM.
- Exhaustion: SHIPMAP=16'h0003, misses at cells 4, 5, 6 -> SHOTS=0, then LOSE=1. START -> SHOTS=3, HITSLEFT=2, STATE=AIM.
- Button held 20 cycles in AIM -> exactly one RESOLVE. Second press during SHOW -> ignored, no extra shot.
- Mid-SHOW NRST=0 -> next cycle all outputs 0, STATE=IDLE. Empty SHIPMAP with START -> WIN directly.
